// File: rtl/seq_shifter.sv
// Multi-cycle 32-bit shifter: srl/sll/sra one bit per clock, start/busy/done handshake.
// The shift-type input is named shift_type because "type" is a reserved word in SystemVerilog.
module seq_shifter (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [4:0]  shamt,
  input  logic [1:0]  shift_type,
  output logic        busy,
  output logic        done,
  output logic [31:0] r,
  output logic [1:0]  dbg_state
);

  // Handshake: start is honoured only in IDLE; busy is high from the cycle after
  // acceptance through the done cycle; done is a one-cycle pulse qualifying r.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  localparam logic [1:0] T_SRL  = 2'b00;
  localparam logic [1:0] T_SLL  = 2'b01;
  localparam logic [1:0] T_PASS = 2'b11;

  state_e      state_q, state_d;
  logic [31:0] w_q, w_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [1:0]  typ_q, typ_d;
  logic [31:0] r_q, r_d;
  logic [31:0] w_shift;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      w_q     <= 32'h0;
      cnt_q   <= 5'd0;
      typ_q   <= 2'b00;
      r_q     <= 32'h0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      cnt_q   <= cnt_d;
      typ_q   <= typ_d;
      r_q     <= r_d;
    end
  end

  // sra reuses w[31], which always still holds the operand's original sign bit.
  always_comb begin
    w_shift = {w_q[31], w_q[31:1]};
    if (typ_q == T_SRL) w_shift = {1'b0, w_q[31:1]};
    else if (typ_q == T_SLL) w_shift = {w_q[30:0], 1'b0};
  end

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    cnt_d   = cnt_q;
    typ_d   = typ_q;
    r_d     = r_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          w_d   = a;
          cnt_d = shamt;
          typ_d = shift_type;
          if (shamt == 5'd0 || shift_type == T_PASS) begin
            r_d     = a;
            state_d = S_DONE;
          end else begin
            state_d = S_SHIFT;
          end
        end
      end
      S_SHIFT: begin
        w_d   = w_shift;
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd1) begin
          r_d     = w_shift;
          state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign r         = r_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_seq_shifter.sv
// Randomised scoreboard bench for seq_shifter against an arithmetic shift model.
module tb_seq_shifter;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] a;
  logic [4:0]  shamt;
  logic [1:0]  shift_type;
  logic        busy;
  logic        done;
  logic [31:0] r;
  logic [1:0]  dbg_state;

  seq_shifter dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a          (a),
    .shamt      (shamt),
    .shift_type (shift_type),
    .busy       (busy),
    .done       (done),
    .r          (r),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [31:0] exp_q[$];
  int          last_acc  = -10;
  int          last_done = -10;
  logic [31:0] r_hold    = 32'h0;
  int          checks    = 0;
  int          failures  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] model_r(input logic [31:0] x, input logic [4:0] s,
                                          input logic [1:0] t);
    logic [31:0] res;
    case (t)
      2'b00:   res = x >> s;
      2'b01:   res = x << s;
      2'b10:   res = $unsigned($signed(x) >>> s);
      default: res = x;
    endcase
    return res;
  endfunction

  function automatic int model_lat(input logic [4:0] s, input logic [1:0] t);
    return (s == 5'd0 || t == 2'b11) ? 1 : int'(s) + 1;
  endfunction

  // ---------------- driver ----------------
  // Called at a falling edge: sets inputs for the current cycle and, if the
  // reference considers the unit idle, records the acceptance.
  task automatic drive(input logic st, input logic [31:0] x, input logic [4:0] s,
                       input logic [1:0] t);
    start = st; a = x; shamt = s; shift_type = t;
    if (st && !rst && cyc > last_done) begin
      last_acc  = cyc;
      last_done = cyc + model_lat(s, t);
      exp_q.push_back(model_r(x, s, t));
    end
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 100 && !(cyc > last_done); k++) @(negedge clk);
    if (k == 100) begin
      failures++;
      $display("FAIL wait_idle timeout at cycle %0d", cyc);
    end
  endtask

  task automatic issue(input logic [31:0] x, input logic [4:0] s, input logic [1:0] t);
    wait_idle();
    drive(1'b1, x, s, t);
    @(negedge clk);
    drive(1'b0, $urandom, 5'($urandom), 2'($urandom));
  endtask

  // ---------------- monitor ----------------
  always @(posedge clk) begin
    #1;
    chk("busy", {31'b0, busy}, {31'b0, (cyc > last_acc) && (cyc <= last_done)});
    chk("done", {31'b0, done}, {31'b0, cyc == last_done});
    if (done) begin
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL spurious_done at cycle %0d: r=%h", cyc, r);
      end else begin
        r_hold = exp_q.pop_front();
        chk("result", r, r_hold);
      end
    end else begin
      chk("r_hold", r, r_hold);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    start = 1'b0; a = 32'h0; shamt = 5'd0; shift_type = 2'b00;
    repeat (3) @(negedge clk);
    chk("reset_busy", {31'b0, busy}, 32'h0);
    chk("reset_done", {31'b0, done}, 32'h0);
    chk("reset_r", r, 32'h0);
    rst = 1'b0;

    // Reset mid-shift: abort in cycle 5 of a 20-bit sll.
    issue(32'hFFFF_FFFF, 5'd20, 2'b01);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    last_acc = -10; last_done = -10; r_hold = 32'h0;
    #1;
    chk("midrst_busy", {31'b0, busy}, 32'h0);
    chk("midrst_done", {31'b0, done}, 32'h0);
    chk("midrst_r", r, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Directed corner cases.
    issue(32'h8000_0000, 5'd31, 2'b00);
    issue(32'h8000_00F0, 5'd4,  2'b10);
    issue(32'h0000_0001, 5'd31, 2'b01);
    issue(32'h1234_5678, 5'd0,  2'b00);
    issue(32'hCAFE_BABE, 5'd17, 2'b11);
    issue(32'h8000_0001, 5'd1,  2'b10);

    // Start held high with changing operands during a shamt=3 operation.
    wait_idle();
    drive(1'b1, 32'hF0F0_0000, 5'd3, 2'b10);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive(1'b1, $urandom, 5'($urandom_range(1, 31)), 2'($urandom_range(0, 2)));
    end
    @(negedge clk);
    drive(1'b0, 32'h0, 5'd0, 2'b00);

    // Random operations with random idle gaps.
    for (int n = 0; n < 40; n++) begin
      issue($urandom, 5'($urandom), 2'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    wait_idle();
    repeat (3) @(negedge clk);
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_shifter.md
# seq_shifter

Multi-cycle shift unit for the area-reduced core variant: performs srl, sll and sra one bit position per clock instead of through a single-cycle barrel network. Takes the same operand, shift-amount and shift-type encoding as the execute-stage shift path. Reports completion through a start/busy/done handshake so the pipeline control stalls the execute stage while a shift is in flight.

## Interface
- Parameters: none (datapath fixed at 32 bits, shift amount 5 bits).
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request pulse; sampled only in IDLE.
- a  input  32  operand; sampled with start.
- shamt  input  5  shift amount 0..31; sampled with start.
- type  input  2  shift type: 00 srl, 01 sll, 10 sra, 11 pass-through (r = a).
- busy  output  1  high whenever the unit is not IDLE.
- done  output  1  one-cycle pulse; r is valid in that cycle.
- r  output  32  registered result; holds until the next completion or reset.

## Operation
- States:
  - IDLE: waiting for a request.
  - SHIFT: one bit position shifted per cycle.
  - DONE: one cycle, result presented.
- Internal state: working register `w[31:0]`, down-counter `cnt[4:0]`, latched `typ[1:0]`.
- IDLE with start=1 at a clock edge:
  - Load `w=a`, `cnt=shamt`, `typ=type`.
  - If shamt==0 or type==11, go to DONE and load `r=a`.
  - Otherwise go to SHIFT.
- IDLE with start=0: stay in IDLE; w, cnt and r hold.
- SHIFT, at each edge:
  - Shift w by one position:
    - srl: `w={1'b0,w[31:1]}`.
    - sll: `w={w[30:0],1'b0}`.
    - sra: `w={w[31],w[31:1]}`.
  - Decrement cnt.
  - If cnt==1 before the edge, go to DONE and load r with the shifted value.
- DONE: assert done. Go to IDLE at the next edge unconditionally.
- start while busy (SHIFT or DONE) is ignored. It is not queued; the requester must re-assert start once busy=0.
- Inputs a, shamt and type are don't-care except in the cycle where start is accepted. Changing them mid-operation has no effect.
- sra replicates the operand's bit 31 as sampled at start, for the full shift count.

## Timing
- Reset (asynchronous, any state): state=IDLE, busy=0, done=0, r=32'h0, w=0, cnt=0. An operation in flight is dropped and no done is produced.
- Cycle numbering: start is high in cycle 0 and is sampled at the edge ending cycle 0.
- Latency:
  - done is high in cycle shamt+1 for shamt≥1.
  - done is high in cycle 1 for shamt==0 or type==11.
  - Throughput is one operation per shamt+2 cycles (3 cycles minimum, including the IDLE cycle).
- busy:
  - High from cycle 1 through the done cycle inclusive.
  - Low in the cycle after done, which is the earliest cycle in which a new start is accepted.
- done is exactly one cycle wide.
- r changes only on the edge entering DONE, or on reset.
- busy and done are registered (decoded from the state register only). No combinational path from start to busy or done.
- Maximum latency is shamt=31: done in cycle 32.
- Release of rst is treated as a synchronous event by the surrounding logic. The first start is accepted at the first rising edge after rst falls.

## Test plan
- Reset mid-shift: start with a=32'hFFFF_FFFF, shamt=20, type=01; assert rst in cycle 5 -> busy=0, done=0 and r=0 immediately; no done pulse follows; a fresh start after release completes normally.
- srl: a=32'h8000_0000, shamt=31, type=00 -> done in cycle 32 only, r=32'h0000_0001; busy high in cycles 1..32.
- sra and sll: a=32'h8000_00F0, shamt=4, type=10 -> done in cycle 5, r=32'hF800_000F; then a=32'h0000_0001, shamt=31, type=01 -> r=32'h8000_0000.
- Zero shift and pass-through: shamt=0, type=00, a=32'h1234_5678 -> done in cycle 1, r=32'h1234_5678; type=11, shamt=17, a=32'hCAFE_BABE -> done in cycle 1, r=32'hCAFE_BABE.
- Start while busy: start held high continuously with operands changed every cycle during a shamt=3 operation -> exactly one done, in cycle 4, with the first operands' result; the next operation is accepted in cycle 5 (the first cycle with busy=0), with its done in cycle 5 + shamt + 1.
